// File: rtl/cam_pkg.sv
// Shared types for the CAM: request opcodes and controller states.
package cam_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_FLUSH = 2'd3
  } cam_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } cam_state_e;

endpackage

// File: rtl/cam_lru_tracker.sv
// Per-entry recency ages (0 = MRU, DEPTH-1 = LRU). The ages always form a
// permutation of 0..DEPTH-1, so exactly one entry carries the LRU age.
module cam_lru_tracker #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic             inval,
  input  logic [IDX_W-1:0] inval_idx,
  input  logic             reset_ages,
  output logic [IDX_W-1:0] lru_idx
);

  logic [IDX_W-1:0] ages [DEPTH];
  logic [IDX_W-1:0] touch_age;
  logic [IDX_W-1:0] inval_age;

  assign touch_age = ages[touch_idx];
  assign inval_age = ages[inval_idx];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [IDX_W-1:0] age_reg;
    assign ages[gi] = age_reg;

    // Touch promotes to MRU and ages younger entries; inval demotes to LRU
    // and pulls older entries one step towards MRU.
    always_ff @(posedge clk_i) begin
      if (reset_i || reset_ages) begin
        age_reg <= IDX_W'(gi);
      end else if (touch) begin
        if (IDX_W'(gi) == touch_idx)  age_reg <= '0;
        else if (age_reg < touch_age) age_reg <= age_reg + 1'b1;
      end else if (inval) begin
        if (IDX_W'(gi) == inval_idx)  age_reg <= IDX_W'(DEPTH - 1);
        else if (age_reg > inval_age) age_reg <= age_reg - 1'b1;
      end
    end
  end

  // The unique entry holding the oldest age is the replacement candidate.
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ages[i] == IDX_W'(DEPTH - 1)) lru_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cam_core.sv
// Fully associative key/value store with LRU replacement, single-entry
// invalidate and a multi-cycle flush that clears one entry per cycle.
module cam_core
  import cam_pkg::*;
#(
  parameter int KEY_W = 8,
  parameter int VAL_W = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [KEY_W-1:0] req_key_i,
  input  logic [VAL_W-1:0] req_val_i,
  output logic             rsp_valid_o,
  output logic             rsp_hit_o,
  output logic [VAL_W-1:0] rsp_val_o,
  output logic             rsp_evict_o,
  output logic [KEY_W-1:0] rsp_evict_key_o,
  output logic [VAL_W-1:0] rsp_evict_val_o
);

  localparam int IDX_W = $clog2(DEPTH);

  cam_state_e       state_reg;
  logic [IDX_W-1:0] cnt_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [VAL_W-1:0] val_mem [DEPTH];

  cam_op_e          op;
  logic             accept;
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] lru_idx;
  logic [IDX_W-1:0] victim_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             touch;
  logic             inval;
  logic             reset_ages;

  assign op          = cam_op_e'(req_op_i);
  assign req_ready_o = (state_reg == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (key_mem[gi] == req_key_i);
  end

  // Encode the (at most one) matching entry and the lowest-index free entry.
  always_comb begin
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
      if (!valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign hit        = |match;
  assign victim_idx = free_found ? free_idx : lru_idx;
  assign wr_idx     = hit ? hit_idx : victim_idx;
  assign touch      = accept && ((op == OP_WRITE) || (op == OP_READ && hit));
  assign inval      = accept && (op == OP_INVAL) && hit;
  assign reset_ages = (state_reg == ST_FLUSH) && (cnt_reg == IDX_W'(DEPTH - 1));

  cam_lru_tracker #(.DEPTH(DEPTH)) u_lru (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .touch      (touch),
    .touch_idx  (wr_idx),
    .inval      (inval),
    .inval_idx  (hit_idx),
    .reset_ages (reset_ages),
    .lru_idx    (lru_idx)
  );

  // Key/value storage: written on every accepted WRITE, never reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept && op == OP_WRITE) begin
      key_mem[wr_idx] <= req_key_i;
      val_mem[wr_idx] <= req_val_i;
    end
  end

  // Controller: valid bits, flush sequencing and the registered response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      valid_reg       <= '0;
      rsp_valid_o     <= 1'b0;
      rsp_hit_o       <= 1'b0;
      rsp_val_o       <= '0;
      rsp_evict_o     <= 1'b0;
      rsp_evict_key_o <= '0;
      rsp_evict_val_o <= '0;
    end else begin
      rsp_valid_o     <= 1'b0;
      rsp_hit_o       <= 1'b0;
      rsp_val_o       <= '0;
      rsp_evict_o     <= 1'b0;
      rsp_evict_key_o <= '0;
      rsp_evict_val_o <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_READ: begin
                rsp_valid_o <= 1'b1;
                rsp_hit_o   <= hit;
                rsp_val_o   <= hit ? val_mem[hit_idx] : '0;
              end
              OP_WRITE: begin
                rsp_valid_o       <= 1'b1;
                rsp_hit_o         <= hit;
                valid_reg[wr_idx] <= 1'b1;
                if (!hit && !free_found) begin
                  rsp_evict_o     <= 1'b1;
                  rsp_evict_key_o <= key_mem[victim_idx];
                  rsp_evict_val_o <= val_mem[victim_idx];
                end
              end
              OP_INVAL: begin
                rsp_valid_o <= 1'b1;
                rsp_hit_o   <= hit;
                if (hit) valid_reg[hit_idx] <= 1'b0;
              end
              default: begin
                state_reg <= ST_FLUSH;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
        default: begin
          valid_reg[cnt_reg] <= 1'b0;
          if (cnt_reg == IDX_W'(DEPTH - 1)) begin
            cnt_reg     <= '0;
            state_reg   <= ST_IDLE;
            rsp_valid_o <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_core.sv
// Randomized and directed bench for cam_core: two instances (DEPTH 4 and 8)
// checked against a recency-list reference model.
module tb_cam_core;
  import cam_pkg::*;

  localparam int KW   = 8;
  localparam int VW   = 16;
  localparam int MAXD = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_i;
  logic          req_valid     [2];
  logic [1:0]    req_op        [2];
  logic [KW-1:0] req_key       [2];
  logic [VW-1:0] req_val       [2];
  logic          req_ready     [2];
  logic          rsp_valid     [2];
  logic          rsp_hit       [2];
  logic [VW-1:0] rsp_val       [2];
  logic          rsp_evict     [2];
  logic [KW-1:0] rsp_evict_key [2];
  logic [VW-1:0] rsp_evict_val [2];

  cam_core #(.KEY_W(KW), .VAL_W(VW), .DEPTH(4)) u_dut4 (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_op_i(req_op[0]),
    .req_key_i(req_key[0]), .req_val_i(req_val[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_hit_o(rsp_hit[0]), .rsp_val_o(rsp_val[0]),
    .rsp_evict_o(rsp_evict[0]), .rsp_evict_key_o(rsp_evict_key[0]),
    .rsp_evict_val_o(rsp_evict_val[0])
  );

  cam_core #(.KEY_W(KW), .VAL_W(VW), .DEPTH(8)) u_dut8 (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_op_i(req_op[1]),
    .req_key_i(req_key[1]), .req_val_i(req_val[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_hit_o(rsp_hit[1]), .rsp_val_o(rsp_val[1]),
    .rsp_evict_o(rsp_evict[1]), .rsp_evict_key_o(rsp_evict_key[1]),
    .rsp_evict_val_o(rsp_evict_val[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: contents plus a recency list (index 0 = most recent).
  int            dep [2] = '{4, 8};
  logic          m_valid [2][MAXD];
  logic [KW-1:0] m_key   [2][MAXD];
  logic [VW-1:0] m_val   [2][MAXD];
  int            lst     [2][MAXD];

  task automatic m_reset(input int s);
    for (int i = 0; i < MAXD; i++) begin
      m_valid[s][i] = 1'b0;
      lst[s][i]     = i;
    end
  endtask

  task automatic m_move(input int s, input int e, input bit to_front);
    int p = 0;
    for (int i = 0; i < dep[s]; i++) if (lst[s][i] == e) p = i;
    if (to_front) begin
      for (int i = p; i > 0; i--) lst[s][i] = lst[s][i-1];
      lst[s][0] = e;
    end else begin
      for (int i = p; i < dep[s] - 1; i++) lst[s][i] = lst[s][i+1];
      lst[s][dep[s]-1] = e;
    end
  endtask

  task automatic do_req(input int s, input logic [1:0] op, input logic [KW-1:0] key,
                        input logic [VW-1:0] val, output logic o_hit,
                        output logic [VW-1:0] o_val, output logic o_ev,
                        output logic [KW-1:0] o_ek);
    int            h = -1;
    int            vic;
    int            waited = 0;
    logic          e_hit;
    logic          e_ev = 1'b0;
    logic [VW-1:0] e_val = '0;
    logic [KW-1:0] e_ek = '0;
    logic [VW-1:0] e_evv = '0;
    o_hit = 1'b0; o_val = '0; o_ev = 1'b0; o_ek = '0;
    req_valid[s] = 1'b1; req_op[s] = op; req_key[s] = key; req_val[s] = val;
    @(negedge clk_i);
    while (!req_ready[s] && waited < 20) begin
      waited++;
      @(negedge clk_i);
    end
    if (!req_ready[s]) begin
      chk("ready_timeout", 32'(req_ready[s]), 32'd1);
      req_valid[s] = 1'b0;
      return;
    end
    for (int i = 0; i < dep[s]; i++) if (m_valid[s][i] && m_key[s][i] == key) h = i;
    e_hit = (op != OP_FLUSH) && (h >= 0);
    case (op)
      OP_READ: if (h >= 0) begin
        e_val = m_val[s][h];
        m_move(s, h, 1'b1);
      end
      OP_WRITE: begin
        if (h >= 0) begin
          m_val[s][h] = val;
          m_move(s, h, 1'b1);
        end else begin
          vic = -1;
          for (int i = dep[s] - 1; i >= 0; i--) if (!m_valid[s][i]) vic = i;
          if (vic < 0) vic = lst[s][dep[s]-1];
          e_ev = m_valid[s][vic];
          if (e_ev) begin
            e_ek  = m_key[s][vic];
            e_evv = m_val[s][vic];
          end
          m_key[s][vic] = key; m_val[s][vic] = val; m_valid[s][vic] = 1'b1;
          m_move(s, vic, 1'b1);
        end
      end
      OP_INVAL: if (h >= 0) begin
        m_valid[s][h] = 1'b0;
        m_move(s, h, 1'b0);
      end
      default: ;
    endcase
    @(posedge clk_i); #1;
    req_valid[s] = 1'b0;
    if (op == OP_FLUSH) begin
      // Keep a request pending while busy; it must be ignored.
      req_valid[s] = 1'b1; req_op[s] = OP_WRITE; req_key[s] = key;
      for (int i = 1; i <= dep[s]; i++) begin
        chk("flush_ready_low", 32'(req_ready[s]), 32'd0);
        chk("flush_no_rsp", 32'(rsp_valid[s]), 32'd0);
        @(posedge clk_i); #1;
      end
      req_valid[s] = 1'b0;
      chk("flush_rsp_valid", 32'(rsp_valid[s]), 32'd1);
      chk("flush_rsp_hit", 32'(rsp_hit[s]), 32'd0);
      chk("flush_rsp_evict", 32'(rsp_evict[s]), 32'd0);
      chk("flush_ready_back", 32'(req_ready[s]), 32'd1);
      m_reset(s);
    end else begin
      chk("rsp_valid", 32'(rsp_valid[s]), 32'd1);
      chk("rsp_hit", 32'(rsp_hit[s]), 32'(e_hit));
      chk("rsp_val", 32'(rsp_val[s]), 32'(e_val));
      chk("rsp_evict", 32'(rsp_evict[s]), 32'(e_ev));
      chk("rsp_evict_key", 32'(rsp_evict_key[s]), 32'(e_ek));
      chk("rsp_evict_val", 32'(rsp_evict_val[s]), 32'(e_evv));
    end
    o_hit = rsp_hit[s]; o_val = rsp_val[s]; o_ev = rsp_evict[s]; o_ek = rsp_evict_key[s];
    $display("txn dut%0d op=%0d key=%0h val=%0h hit=%0d rval=%0h evict=%0d ekey=%0h",
             dep[s], op, key, val, rsp_hit[s], rsp_val[s], rsp_evict[s], rsp_evict_key[s]);
  endtask

  logic          r_hit, r_ev;
  logic [VW-1:0] r_val;
  logic [KW-1:0] r_ek;

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_op[s] = 2'd0; req_key[s] = '0; req_val[s] = '0;
      m_reset(s);
    end
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("reset_rsp_val", 32'(rsp_val[s]), 32'd0);
      chk("reset_rsp_evict", 32'(rsp_evict[s]), 32'd0);
    end
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("reset_ready4", 32'(req_ready[0]), 32'd1);
    chk("reset_ready8", 32'(req_ready[1]), 32'd1);

    // DEPTH=4 directed scenarios
    for (int k = 1; k <= 4; k++) begin
      do_req(0, OP_WRITE, KW'(k), VW'(k * 10), r_hit, r_val, r_ev, r_ek);
      chk("fill_miss", 32'(r_hit), 32'd0);
      chk("fill_no_evict", 32'(r_ev), 32'd0);
    end
    do_req(0, OP_READ, 8'd3, '0, r_hit, r_val, r_ev, r_ek);
    chk("read3_val", 32'(r_val), 32'd30);
    do_req(0, OP_READ, 8'd1, '0, r_hit, r_val, r_ev, r_ek);
    do_req(0, OP_WRITE, 8'd5, 16'd50, r_hit, r_val, r_ev, r_ek);
    chk("evict_flag", 32'(r_ev), 32'd1);
    chk("evict_key2", 32'(r_ek), 32'd2);
    do_req(0, OP_READ, 8'd2, '0, r_hit, r_val, r_ev, r_ek);
    chk("read2_miss", 32'(r_hit), 32'd0);
    do_req(0, OP_WRITE, 8'd7, 16'd70, r_hit, r_val, r_ev, r_ek);
    do_req(0, OP_WRITE, 8'd7, 16'd71, r_hit, r_val, r_ev, r_ek);
    chk("rewrite7_hit", 32'(r_hit), 32'd1);
    do_req(0, OP_READ, 8'd7, '0, r_hit, r_val, r_ev, r_ek);
    chk("read7_val", 32'(r_val), 32'd71);
    do_req(0, OP_INVAL, 8'd3, '0, r_hit, r_val, r_ev, r_ek);
    chk("inval3_hit", 32'(r_hit), 32'd1);
    do_req(0, OP_WRITE, 8'd9, 16'd90, r_hit, r_val, r_ev, r_ek);
    chk("write9_no_evict", 32'(r_ev), 32'd0);

    // DEPTH=8 flush
    for (int k = 0; k < 5; k++) do_req(1, OP_WRITE, KW'(k + 20), VW'(k), r_hit, r_val, r_ev, r_ek);
    do_req(1, OP_FLUSH, 8'd0, '0, r_hit, r_val, r_ev, r_ek);
    for (int k = 0; k < 5; k++) begin
      do_req(1, OP_READ, KW'(k + 20), '0, r_hit, r_val, r_ev, r_ek);
      chk("post_flush_miss", 32'(r_hit), 32'd0);
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      int s = int'($urandom_range(0, 1));
      int r = int'($urandom_range(0, 15));
      logic [1:0] op = (r < 6) ? OP_READ : (r < 12) ? OP_WRITE : (r < 15) ? OP_INVAL : OP_FLUSH;
      do_req(s, op, KW'($urandom_range(0, 11)), VW'($urandom), r_hit, r_val, r_ev, r_ek);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1;
        chk("rsp_pulse_end", 32'(rsp_valid[s]), 32'd0);
      end
    end

    // Reset in the middle of a flush on the DEPTH=8 instance
    do_req(1, OP_WRITE, 8'h55, 16'h1234, r_hit, r_val, r_ev, r_ek);
    req_valid[1] = 1'b1; req_op[1] = OP_FLUSH; req_key[1] = '0;
    @(posedge clk_i); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("midflush_busy", 32'(req_ready[1]), 32'd0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    m_reset(0);
    m_reset(1);
    chk("midflush_ready", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("midflush_no_rsp", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk_i); #1;
    end
    do_req(1, OP_READ, 8'h55, '0, r_hit, r_val, r_ev, r_ek);
    chk("after_reset_miss", 32'(r_hit), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
